// File: rtl/muldiv_sequencer_if.sv
// Core-side bundle for the multiply/divide sequencer: requests, HI/LO moves,
// read-hazard hints and the HI/LO/busy/done/stall responses.
interface muldiv_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic        mfhi;
  logic        mflo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, op, op_a, op_b, mthi, mtlo, mfhi, mflo,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, op_a, op_b, mthi, mtlo, mfhi, mflo,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Define MULDIV_FAST_MULT_EN to make multiplies single-cycle; divides stay iterative.
//
// state | meaning
// IDLE  | accept start / MTHI / MTLO
// RUN   | one shift-add or restoring-divide step per cycle, cnt counts down
// SIGN  | sign fixup of the magnitude result and HI/LO write
module muldiv_sequencer (
  input  logic               clk,
  input  logic               rst,
  muldiv_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2
  } state_t;

`ifdef MULDIV_FAST_MULT_EN
  localparam logic FAST_MULT = 1'b1;
`else
  localparam logic FAST_MULT = 1'b0;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] add_sum;
  logic [32:0] part;
  logic        part_ge;
  logic [31:0] rem_nxt;
  logic [63:0] prod_fix;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // operand magnitudes; signed ops strip the sign here and restore it in SIGN
  always_comb begin
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.op_a[31];
    b_neg     = signed_op & bus.op_b[31];
    a_mag     = a_neg ? (~bus.op_a + 32'd1) : bus.op_a;
    b_mag     = b_neg ? (~bus.op_b + 32'd1) : bus.op_b;
  end

  // multiply step: acc holds {partial product, remaining multiplier bits}
  always_comb begin
    add_sum = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? dvs : 32'd0)};
  end

  // divide step: acc[31:0] shifts the dividend out and the quotient in
  always_comb begin
    part    = {rem, acc[31]};
    part_ge = (part >= {1'b0, dvs});
    rem_nxt = part_ge ? (part[31:0] - dvs) : part[31:0];
  end

  always_comb begin
    prod_fix = neg_q ? (~acc + 64'd1) : acc;
    q_fix    = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    r_fix    = neg_r ? (~rem + 32'd1) : rem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = (FAST_MULT && !bus.op[1]) ? S_SIGN : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == 5'd0) begin
          state_nxt = S_SIGN;
        end
      end
      S_SIGN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 5'd0;
      acc      <= 64'd0;
      rem      <= 32'd0;
      dvs      <= 32'd0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == S_SIGN);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cnt      <= 5'd31;
            rem      <= 32'd0;
            is_div   <= bus.op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= bus.op[1] & (bus.op_b == 32'd0);
            dvs      <= bus.op[1] ? b_mag : a_mag;
`ifdef MULDIV_FAST_MULT_EN
            acc      <= bus.op[1] ? {32'd0, a_mag} : ({32'd0, a_mag} * {32'd0, b_mag});
`else
            acc      <= {32'd0, (bus.op[1] ? a_mag : b_mag)};
`endif
          end else begin
            if (bus.mthi) hi_q <= bus.op_a;
            if (bus.mtlo) lo_q <= bus.op_a;
          end
        end
        S_RUN: begin
          cnt <= cnt - 5'd1;
          if (is_div) begin
            rem        <= rem_nxt;
            acc[31:0]  <= {acc[30:0], part_ge};
          end else begin
            acc <= {add_sum, acc[31:1]};
          end
        end
        S_SIGN: begin
          if (is_div) begin
            // a zero divisor leaves the dividend magnitude in rem, so HI
            // re-signs back to op_a; only LO needs forcing
            lo_q <= div_zero ? 32'hFFFF_FFFF : q_fix;
            hi_q <= r_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
        end
        default: begin
          cnt <= 5'd0;
        end
      endcase
    end
  end

  always_comb begin
    bus.hi    = hi_q;
    bus.lo    = lo_q;
    bus.done  = done_q;
    bus.busy  = (state != S_IDLE);
    bus.stall = bus.busy & (bus.start | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo);
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected HI/LO and
// done cycle; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_seen = 0;
  exp_t sb[$];

  muldiv_sequencer_if bus();

  muldiv_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        e = sb.pop_front();
        check32("op_hi", bus.hi, e.hi);
        check32("op_lo", bus.lo, e.lo);
        check32("done_cycle", cyc, e.t);
      end
    end
  end

  function automatic int lat_of(input logic [1:0] op);
    int l;
    l = 33;
`ifdef MULDIV_FAST_MULT_EN
    if (!op[1]) l = 1;
`endif
    return l;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", bus.busy, n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d ops still pending, expected 0", sb.size());
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input bit track);
    exp_t e;
    wait_idle();
    bus.start = 1'b1;
    bus.op    = op;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e.hi = ehi;
    e.lo = elo;
    e.t  = cyc + lat_of(op);
    if (track) sb.push_back(e);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bad;
    int n;
    int d0;
    exp_t e;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.op_a  = 32'd0;
    bus.op_b  = 32'd0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.mfhi  = 1'b0;
    bus.mflo  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check32("rst_hi", bus.hi, 32'd0);
    check32("rst_lo", bus.lo, 32'd0);
    check32("rst_busy", {31'd0, bus.busy}, 32'd0);
    check32("rst_done", {31'd0, bus.done}, 32'd0);
    check32("rst_stall", {31'd0, bus.stall}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // directed arithmetic, issued back to back
    issue(OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    issue(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    issue(OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b1);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b1);
    issue(OP_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1);
    issue(OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    drain();

    // reads in IDLE never stall
    bus.mfhi = 1'b1;
    bus.mflo = 1'b1;
    #1;
    check32("idle_read_stall", {31'd0, bus.stall}, 32'd0);
    check32("idle_read_hi", bus.hi, 32'hFFFF_FFFB);
    bus.mfhi = 1'b0;
    bus.mflo = 1'b0;
    @(posedge clk); #1;

    // MTHI+MTLO together
    bus.op_a = 32'hA5A5_A5A5;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check32("mthilo_hi", bus.hi, 32'hA5A5_A5A5);
    check32("mthilo_lo", bus.lo, 32'hA5A5_A5A5);
    check32("mthilo_no_done", {31'd0, bus.done}, 32'd0);

    // start wins over mtlo
    wait_idle();
    bus.start = 1'b1;
    bus.mtlo  = 1'b1;
    bus.op    = OP_MULTU;
    bus.op_a  = 32'hFFFF_FFFF;
    bus.op_b  = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    e.hi = 32'h0000_0001;
    e.lo = 32'hFFFF_FFFE;
    e.t  = cyc + lat_of(OP_MULTU);
    sb.push_back(e);
    check32("start_mtlo_lo", bus.lo, 32'hA5A5_A5A5);
    check32("start_mtlo_busy", {31'd0, bus.busy}, 32'd1);
    drain();

    // MFLO hazard during a divide
    issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    bus.mflo = 1'b1;
    bad = 0;
    n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 60) begin
      if (bus.stall !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    check32("mflo_stall_cycles_bad", bad, 32'd0);
    check32("mflo_busy_fell", {31'd0, bus.busy}, 32'd0);
    check32("mflo_stall_released", {31'd0, bus.stall}, 32'd0);
    check32("mflo_lo_new", bus.lo, 32'd14);
    @(posedge clk); #1;
    bus.mflo = 1'b0;
    drain();

    // MTHI held under stall lands only in IDLE
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    bus.mthi = 1'b1;
    bus.op_a = 32'h0000_1234;
    bad = 0;
    n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 60) begin
      if (bus.stall !== 1'b1 || bus.hi !== 32'd2) bad++;
      @(negedge clk);
      n++;
    end
    check32("mthi_hold_bad", bad, 32'd0);
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    check32("mthi_late_hi", bus.hi, 32'h0000_1234);
    check32("mthi_late_lo", bus.lo, 32'hFFFF_FFFD);
    drain();

    // reset mid-divide aborts with no done
    issue(OP_DIV, 32'd64, 32'd3, 32'd0, 32'd0, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    d0 = done_seen;
    rst = 1'b0;
    #1;
    check32("abort_hi", bus.hi, 32'd0);
    check32("abort_lo", bus.lo, 32'd0);
    check32("abort_busy", {31'd0, bus.busy}, 32'd0);
    check32("abort_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    check32("abort_no_done", done_seen - d0, 32'd0);

    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
